// File: rtl/fc_argmax_stage_pkg.sv
// Shared definitions for the fc argmax stage and the fc stage wrappers:
// FSM state encoding, default geometry and the index-width helper.
package fc_argmax_stage_pkg;

  // Default sample width and vector length used by the fc stage wrappers.
  localparam int FC_WIDTH = 20;
  localparam int FC_M     = 6;

  // Two-phase handshake FSM: gather M samples, then present one result beat.
  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } argmax_state_t;

  // Index width for an M-entry vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_argmax_stage.sv
// Streaming argmax over M signed samples. Samples arrive one per handshake;
// after the M-th sample the running maximum and its position are presented
// as a single output beat. Input and output phases never overlap, so
// input_ready is a pure function of the registered state.
module fc_argmax_stage
  import fc_argmax_stage_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int M     = FC_M,
  parameter int IDXW  = idx_width(M)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic signed [WIDTH-1:0] input_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic signed [WIDTH-1:0] output_data,
  output logic [IDXW-1:0]         output_index
);

  argmax_state_t           r_state;
  argmax_state_t           w_state_nxt;
  logic [IDXW-1:0]         r_cnt;
  logic signed [WIDTH-1:0] r_max;
  logic [IDXW-1:0]         r_idx;

  logic w_accept;
  logic w_last;
  logic w_first;
  logic w_greater;

  // Acceptance is decoded from the state register, not from input_ready,
  // so there is no path from output_ready into the input side.
  assign w_accept  = input_valid && (r_state == COLLECT);
  assign w_last    = (r_cnt == IDXW'(M - 1));
  assign w_first   = (r_cnt == '0);
  // Strict compare: equal values leave the earlier index in place.
  assign w_greater = (input_data > r_max);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt  = r_state;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    case (r_state)
      COLLECT: begin
        input_ready = 1'b1;
        if (w_accept && w_last) w_state_nxt = EMIT;
      end
      EMIT: begin
        output_valid = 1'b1;
        if (output_ready) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Element counter: wraps to zero on the last sample of a vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) r_cnt <= '0;
      else        r_cnt <= r_cnt + IDXW'(1);
    end
  end

  // Running maximum: first sample loads unconditionally, later samples
  // replace it only when strictly larger.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (w_accept && (w_first || w_greater)) begin
      r_max <= input_data;
      r_idx <= r_cnt;
    end
  end

  // Result registers are frozen during EMIT, so the beat is stable under
  // backpressure.
  assign output_data  = r_max;
  assign output_index = r_idx;

endmodule

// File: tb/tb_fc_argmax_stage.sv
// Self-checking bench for fc_argmax_stage: table vectors with hand-computed
// results, corner-case sequences, and randomized traffic scored against a
// queue-based argmax model.
module tb_fc_argmax_stage;
  import fc_argmax_stage_pkg::*;

  localparam int WIDTH = 20;
  localparam int M     = 6;
  localparam int IDXW  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    input_valid;
  logic                    input_ready;
  logic signed [WIDTH-1:0] input_data;
  logic                    output_valid;
  logic                    output_ready;
  logic signed [WIDTH-1:0] output_data;
  logic [IDXW-1:0]         output_index;

  fc_argmax_stage #(.WIDTH(WIDTH), .M(M), .IDXW(IDXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_index (output_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int d; int i; } res_t;
  int   vq[$];
  res_t eq[$];
  int   cyc = 0;
  int   last_acc_cyc = -10;
  int   beats = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc++;

  // Observe handshakes mid-cycle, when all bench-driven inputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      vq.delete();
      eq.delete();
      prev_ov = 1'b0;
    end else begin
      if (output_valid && !prev_ov) chk("latency", cyc, last_acc_cyc + 1);
      if (input_ready === output_valid) chk("ready_valid_exclusive", input_ready, !output_valid);
      if (output_valid && output_ready) begin
        res_t r;
        beats++;
        if (eq.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          r = eq.pop_front();
          chk("beat_data", longint'(output_data), r.d);
          chk("beat_index", longint'(output_index), r.i);
        end
      end
      if (input_valid && input_ready) begin
        vq.push_back(int'(input_data));
        if (vq.size() == M) begin
          res_t r;
          r.d = vq[0];
          r.i = 0;
          foreach (vq[k]) if (vq[k] > r.d) begin r.d = vq[k]; r.i = k; end
          eq.push_back(r);
          vq.delete();
          last_acc_cyc = cyc;
        end
      end
      prev_ov = output_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct { int s[M]; int d; int i; } vec_t;
  vec_t tbl[6];

  // Back-to-back feed; COLLECT guarantees acceptance every cycle.
  task automatic feed(input int s[M]);
    for (int k = 0; k < M; k++) begin
      input_valid = 1'b1;
      input_data  = WIDTH'(s[k]);
      step();
    end
    input_valid = 1'b0;
  endtask

  initial begin
    int seq[M];
    int base;
    int acc;
    int guard;
    bit take;

    tbl[0].s = '{5, -3, 12, 7, 12, 0};                   tbl[0].d = 12;      tbl[0].i = 2;
    tbl[1].s = '{-524288, -524288, -524288, -524288, -524288, -524288};
                                                         tbl[1].d = -524288; tbl[1].i = 0;
    tbl[2].s = '{1, 2, 3, 4, 5, 524287};                 tbl[2].d = 524287;  tbl[2].i = 5;
    tbl[3].s = '{-1, -2, -3, -4, -5, -6};                tbl[3].d = -1;      tbl[3].i = 0;
    tbl[4].s = '{3, 3, 9, 9, -7, 9};                     tbl[4].d = 9;       tbl[4].i = 2;
    tbl[5].s = '{-100, -50, -50, -200, -51, -49};        tbl[5].d = -49;     tbl[5].i = 5;

    reset = 1'b1; input_valid = 1'b0; input_data = '0; output_ready = 1'b0;
    step(); step();
    chk("reset_output_valid", output_valid, 0);
    chk("reset_input_ready", input_ready, 1);
    chk("reset_max", longint'(output_data), 0);
    chk("reset_idx", longint'(output_index), 0);
    reset = 1'b0;
    step();
    chk("post_reset_input_ready", input_ready, 1);

    // Table vectors, output_ready held high.
    output_ready = 1'b1;
    foreach (tbl[t]) begin
      feed(tbl[t].s);
      chk($sformatf("tbl%0d_valid", t), output_valid, 1);
      chk($sformatf("tbl%0d_data", t), longint'(output_data), tbl[t].d);
      chk($sformatf("tbl%0d_index", t), longint'(output_index), tbl[t].i);
      step();
      chk($sformatf("tbl%0d_released", t), output_valid, 0);
      chk($sformatf("tbl%0d_ready_back", t), input_ready, 1);
    end

    // Backpressure hold with input_valid asserted at 1000 throughout EMIT.
    output_ready = 1'b0;
    feed(tbl[2].s);
    input_valid = 1'b1; input_data = 1000;
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", output_valid, 1);
      chk("hold_ready_low", input_ready, 0);
      chk("hold_data", longint'(output_data), 524287);
      chk("hold_index", longint'(output_index), 5);
      step();
    end
    output_ready = 1'b1;
    step();
    chk("hs_valid_drop", output_valid, 0);
    chk("hs_ready_rise", input_ready, 1);
    step();                 // 1000 taken here as element 0
    seq = '{0, 1, 2, 3, 4, 5};
    for (int k = 1; k < M; k++) begin
      input_data = WIDTH'(seq[k]);
      step();
    end
    input_valid = 1'b0;
    chk("after_emit_data", longint'(output_data), 1000);
    chk("after_emit_index", longint'(output_index), 0);
    step();

    // Reset mid-vector, then a clean vector.
    base = beats;
    seq = '{9, 8, 7, 0, 0, 0};
    for (int k = 0; k < 3; k++) begin
      input_valid = 1'b1; input_data = WIDTH'(seq[k]); step();
    end
    input_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    chk("midreset_ready", input_ready, 1);
    feed('{1, 2, 3, 4, 5, 6});
    chk("midreset_data", longint'(output_data), 6);
    chk("midreset_index", longint'(output_index), 5);
    step();
    chk("midreset_beats", beats - base, 1);

    // Reset while a result is pending: no beat is produced.
    output_ready = 1'b0;
    base = beats;
    feed(tbl[0].s);
    chk("pend_valid", output_valid, 1);
    reset = 1'b1; output_ready = 1'b1; step(); reset = 1'b0;
    chk("pend_discard_valid", output_valid, 0);
    step();
    chk("pend_discard_beats", beats - base, 0);

    // Randomized: three vectors with input gaps and random backpressure.
    base  = beats;
    acc   = 0;
    guard = 0;
    while ((beats - base < 3) && guard < 2000) begin
      input_valid  = (acc < 3 * M) && ($urandom_range(0, 2) != 0);
      input_data   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 7) - 4)
                                                 : WIDTH'($urandom);
      output_ready = ($urandom_range(0, 1) == 1);
      take = input_valid && input_ready;
      step();
      if (take) acc++;
      guard++;
    end
    input_valid = 1'b0;
    chk("rand_timeout", guard < 2000, 1);
    chk("rand_beats", beats - base, 3);
    chk("rand_scoreboard_empty", eq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_argmax_stage.md
FC_ARGMAX_STAGE -- requirements
Module: fc_argmax_stage

Interface
REQ-001 Parameter WIDTH, default 20: signed sample width, matching the fc stage output.
REQ-002 Parameter M, default 6: number of samples per output vector; legal range 2..1024.
REQ-003 Parameter IDXW, default max(1,$clog2(M)): index width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 input_valid  input  1  upstream sample present.
REQ-007 input_ready  output  1  block accepts a sample this cycle.
REQ-008 input_data  input  WIDTH  signed two's-complement sample.
REQ-009 output_valid  output  1  result beat present.
REQ-010 output_ready  input  1  downstream accepts the result beat.
REQ-011 output_data  output  WIDTH  signed maximum of the vector.
REQ-012 output_index  output  IDXW  position 0..M-1 of that maximum.

Function
REQ-013 A sample SHALL be accepted only in a cycle where input_valid and input_ready are both 1.
REQ-014 An output beat SHALL be consumed only in a cycle where output_valid and output_ready are both 1.
REQ-015 FSM states: COLLECT and EMIT, with reset state COLLECT.
REQ-016 In COLLECT, input_ready SHALL be 1 and output_valid SHALL be 0.
REQ-017 In EMIT, input_ready SHALL be 0 and output_valid SHALL be 1.
REQ-018 An element counter cnt SHALL be 0 on reset and increment on each accepted sample.
REQ-019 On acceptance with cnt==0, max_r SHALL load input_data unconditionally and idx_r SHALL load 0.
REQ-020 On acceptance with cnt>0, max_r/idx_r SHALL update to input_data/cnt only when input_data > max_r (signed compare).
REQ-021 Ties SHALL keep the lower index.
REQ-022 On acceptance with cnt==M-1: cnt SHALL wrap to 0, the comparison SHALL still apply, and the next state SHALL be EMIT.
REQ-023 output_valid SHALL assert in the cycle immediately after the M-th sample is accepted (latency 1 cycle).
REQ-024 output_data SHALL equal max_r and output_index SHALL equal idx_r, held stable while output_valid=1 and output_ready=0.
REQ-025 On the output handshake, the state SHALL return to COLLECT next cycle; input_ready rises that cycle, not combinationally on output_ready.
REQ-026 input_valid SHALL be ignored in EMIT; no sample is lost because input_ready=0.
REQ-027 Upstream gaps (input_valid=0 in COLLECT) SHALL hold cnt, max_r and idx_r unchanged.
REQ-028 Maximum throughput SHALL be one vector per M+1 cycles.
REQ-029 No arithmetic beyond signed compare SHALL occur; no saturation is needed and widths are preserved.

Reset
REQ-030 When reset=1 at a clock edge: state=COLLECT, cnt=0, max_r=0, idx_r=0.
REQ-031 After reset, output_valid=0 and input_ready=1 in the following cycle.
REQ-032 Reset mid-vector or during EMIT SHALL discard the partial or pending result with no output beat produced.
REQ-033 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-034 A shared package SHALL hold the state enum (COLLECT, EMIT) and default WIDTH/M constants, reused by the fc stage wrappers.
REQ-035 The block SHALL be one module with no sub-module; counter, comparator and FSM SHALL live in separate always blocks.
REQ-036 The design SHALL use no memories and no combinational path from output_ready to input_ready.

Verification
REQ-037 Feed 5,-3,12,7,12,0 back-to-back, output_ready=1 -> one beat, data=12, index=2, exactly 1 cycle after the 6th accept.
REQ-038 Feed six -524288 values -> data=-524288, index=0 (first-element load and tie rule).
REQ-039 Feed a vector with max 524287 at position 5, output_ready=0 for 10 cycles -> output_valid held and data stable, input_ready=0 throughout; handshake, then input_ready=1 next cycle.
REQ-040 Random input_valid gaps across three vectors with a scoreboard argmax model -> every beat matches and beat count=3.
REQ-041 Assert reset after the 3rd sample, then feed a full vector 1,2,3,4,5,6 -> single beat, data=6, index=5, no stale beat.
REQ-042 Assert input_valid=1 continuously during EMIT with values 1000 -> no acceptance; the next vector's first element is taken only after the handshake.
